// File: rtl/conv_viterbi_dec.sv
// Hard-decision Viterbi decoder, rate-1/2 K=4 (octal 17/13), 8 states.
// One ACS step per clock, then one traceback step per clock.
module conv_viterbi_dec #(
   parameter int NBITS    = 48,
   parameter int PM_W     = 8,
   parameter int INIT_INF = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2*NBITS-1:0] fec_in,
   output logic [NBITS-1:0]   dout,
   output logic [PM_W-1:0]    metric,
   output logic               busy,
   output logic               done
);

   localparam int CW = 2 * NBITS;
   localparam int SW = $clog2(NBITS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACS,
      S_TB,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     fec_q;
   logic [PM_W-1:0]   pm_q [8];
   logic [PM_W-1:0]   pm_d [8];
   logic [7:0]        dec_d;
   logic [7:0]        surv_q [NBITS];
   logic [SW-1:0]     step_q;
   logic [2:0]        st_q;
   logic [NBITS-1:0]  dout_q;
   logic [PM_W-1:0]   metric_q;
   logic              busy_q;
   logic              done_q;

   logic              accept;
   logic              last_step;
   logic [1:0]        rx_pair;
   logic [2:0]        best_st;
   logic [PM_W-1:0]   best_pm;
   logic [2:0]        tb_st;
   logic              tb_bit;
   logic [SW-1:0]     out_idx;

   // Branch metric: Hamming distance between received pair and the
   // {p1,p0} emitted when entering ns from predecessor {ns[1:0],b}.
   function automatic logic [1:0] bmet(
      input logic [1:0] rx,
      input logic [2:0] ns,
      input logic       b
   );
      logic p0;
      logic p1;
      p0 = ns[2] ^ ns[1] ^ ns[0] ^ b;
      p1 = ns[2] ^ ns[0] ^ b;
      return {1'b0, rx[1] ^ p1} + {1'b0, rx[0] ^ p0};
   endfunction

   // Metric addition that clamps at all-ones instead of wrapping.
   function automatic logic [PM_W-1:0] sat_add(
      input logic [PM_W-1:0] a,
      input logic [1:0]      d
   );
      logic [PM_W:0] s;
      s = {1'b0, a} + {{(PM_W-1){1'b0}}, d};
      return s[PM_W] ? '1 : s[PM_W-1:0];
   endfunction

   assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
   assign last_step = (step_q == SW'(NBITS - 1));
   assign rx_pair   = fec_q[CW-1 -: 2];
   assign out_idx   = SW'(NBITS - 1) - step_q;

   // Add-compare-select for all eight next states; ties keep b=0.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         logic [2:0]      ns;
         logic [PM_W-1:0] c0;
         logic [PM_W-1:0] c1;
         ns = 3'(i);
         c0 = sat_add(pm_q[{ns[1:0], 1'b0}], bmet(rx_pair, ns, 1'b0));
         c1 = sat_add(pm_q[{ns[1:0], 1'b1}], bmet(rx_pair, ns, 1'b1));
         dec_d[i] = (c1 < c0);
         pm_d[i]  = (c1 < c0) ? c1 : c0;
      end
   end

   // Best final state: smallest metric, lowest index wins ties.
   always_comb begin
      best_st = 3'd0;
      best_pm = pm_q[0];
      for (int i = 1; i < 8; i++) begin
         if (pm_q[i] < best_pm) begin
            best_st = 3'(i);
            best_pm = pm_q[i];
         end
      end
   end

   // Traceback starts from the best state, then follows st_q.
   always_comb begin
      tb_st  = last_step ? best_st : st_q;
      tb_bit = surv_q[step_q][tb_st];
   end

   // Codeword register: loaded on accept, shifted one pair per ACS step.
   always_ff @(posedge clk) begin
      if (accept) begin
         fec_q <= fec_in;
      end else if (state_q == S_ACS) begin
         fec_q <= fec_q << 2;
      end
   end

   // Survivor memory: one row of decision bits per trellis step.
   always_ff @(posedge clk) begin
      if (state_q == S_ACS) begin
         surv_q[step_q] <= dec_d;
      end
   end

   // Control FSM, path metrics, traceback and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         step_q   <= '0;
         st_q     <= '0;
         dout_q   <= '0;
         metric_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            pm_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  pm_q[0] <= '0;
                  for (int i = 1; i < 8; i++) begin
                     pm_q[i] <= PM_W'(INIT_INF);
                  end
                  step_q  <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= S_ACS;
               end
            end
            S_ACS: begin
               for (int i = 0; i < 8; i++) begin
                  pm_q[i] <= pm_d[i];
               end
               if (last_step) begin
                  state_q <= S_TB;
               end else begin
                  step_q <= step_q + 1'b1;
               end
            end
            S_TB: begin
               if (last_step) begin
                  metric_q <= best_pm;
               end
               dout_q[out_idx] <= tb_st[2];
               st_q <= {tb_st[1:0], tb_bit};
               if (step_q == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  step_q <= step_q - 1'b1;
               end
            end
         endcase
      end
   end

   assign dout   = dout_q;
   assign metric = metric_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_conv_viterbi_dec.sv
// Directed bench for conv_viterbi_dec.
// Hand-picked codewords, error patterns, reset and start-collision cases.
module tb_conv_viterbi_dec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [95:0] fec_in = '0;
   logic [47:0] dout;
   logic [7:0]  metric;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   conv_viterbi_dec dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .fec_in (fec_in),
      .dout   (dout),
      .metric (metric),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [95:0] got,
                      input logic [95:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference encoder: state {u[k-1],u[k-2],u[k-3]}, pair {p1,p0}.
   function automatic logic [95:0] encode(input logic [47:0] v);
      logic [2:0]  s;
      logic        u;
      logic [95:0] c;
      s = '0;
      c = '0;
      for (int k = 0; k < 48; k++) begin
         u = v[47-k];
         c[95-2*k] = u ^ s[1] ^ s[0];
         c[94-2*k] = u ^ s[2] ^ s[1] ^ s[0];
         s = {u, s[2:1]};
      end
      return c;
   endfunction

   task automatic wait_done(input int pulse_at, input logic [95:0] pf,
                            output int cyc, output bit busy_ok);
      cyc = 0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 200) begin
         if (cyc == pulse_at) begin
            fec_in = pf;
            start  = 1'b1;
         end
         tick();
         start = 1'b0;
         cyc++;
         if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
      end
   endtask

   task automatic run(input string tag, input logic [95:0] f,
                      input int pulse_at, input logic [95:0] pf,
                      input logic [47:0] exp_d, input logic [7:0] exp_m);
      int cyc;
      bit bok;
      fec_in = f;
      start  = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, ".acc_busy"}, 96'(busy), 96'd1);
      chk({tag, ".acc_done"}, 96'(done), 96'd0);
      wait_done(pulse_at, pf, cyc, bok);
      chk({tag, ".latency"}, 96'(cyc), 96'd96);
      chk({tag, ".busy_run"}, 96'(bok), 96'd1);
      chk({tag, ".busy_end"}, 96'(busy), 96'd0);
      chk({tag, ".dout"}, 96'(dout), 96'(exp_d));
      chk({tag, ".metric"}, 96'(metric), 96'(exp_m));
   endtask

   localparam logic [95:0] IMP  = 96'hDF0000000000000000000000;
   localparam logic [47:0] VEC  = 48'hA5C3_1E96_0F7B;
   localparam logic [47:0] IMPD = 48'h800000000000;

   initial begin
      logic [95:0] imp_e;
      logic [95:0] rnd_e;

      imp_e = IMP ^ (96'd1 << 50);
      rnd_e = encode(VEC) ^ (96'd1 << 85) ^ (96'd1 << 34);

      tick();
      tick();
      chk("rst.busy", 96'(busy), 96'd0);
      chk("rst.done", 96'(done), 96'd0);
      chk("rst.dout", 96'(dout), 96'd0);
      chk("rst.metric", 96'(metric), 96'd0);
      rst = 1'b0;
      tick();

      run("zero", 96'd0, -1, 96'd0, 48'd0, 8'd0);
      tick();
      tick();
      tick();
      chk("zero.hold_done", 96'(done), 96'd1);
      chk("zero.hold_busy", 96'(busy), 96'd0);

      run("imp", IMP, -1, 96'd0, IMPD, 8'd0);
      run("imp1e", imp_e, -1, 96'd0, IMPD, 8'd1);
      run("rnd2e", rnd_e, -1, 96'd0, VEC, 8'd2);

      fec_in = IMP;
      start  = 1'b1;
      tick();
      start = 1'b0;
      repeat (29) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst.busy", 96'(busy), 96'd0);
      chk("midrst.done", 96'(done), 96'd0);
      chk("midrst.dout", 96'(dout), 96'd0);
      chk("midrst.metric", 96'(metric), 96'd0);
      repeat (3) tick();
      chk("midrst.idle", 96'(busy), 96'd0);

      run("after_rst", imp_e, -1, 96'd0, IMPD, 8'd1);

      run("ignore", rnd_e, 9, IMP, VEC, 8'd2);
      run("from_done", IMP, -1, 96'd0, IMPD, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv_viterbi_dec.md
Name: conv_viterbi_dec

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=4 convolutional code (8 states). It sits directly downstream of the convolutional encoder.
- Takes one 96-bit codeword (48 symbol pairs) and recovers the 48 information bits MSB-first, ready for the serializer.
- The code runs in one clock domain. It is multi-cycle: 48 add-compare-select (ACS) cycles, then 48 traceback cycles.

Parameters:
- NBITS, 48, information bits per block; the codeword is 2*NBITS bits.
- PM_W, 8, path-metric width. Metrics saturate at 2^PM_W-1.
- INIT_INF, 64, initial metric of states 1..7.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load request; sampled only when busy=0.
- fec_in  input  2*NBITS  codeword. Pair j occupies bits [2*NBITS-1-2j -: 2] as {p1_j,p0_j}.
- dout  output  NBITS  decoded bits; dout[NBITS-1] is the first information bit.
- metric  output  PM_W  winning path metric (Hamming distance to the decoded path).
- busy  output  1  high from start acceptance until done.
- done  output  1  high while dout/metric are valid; held until the next accepted start or rst.

Behaviour:
- Code definition:
  - u_k is the input bit; state s = {u_{k-1},u_{k-2},u_{k-3}}. The encoder starts in state 0, and the block is not terminated.
  - p0 = u_k^u_{k-1}^u_{k-2}^u_{k-3} (octal 17).
  - p1 = u_k^u_{k-2}^u_{k-3} (octal 13).
  - Next state = {u_k, s[2:1]}.
- Reset (rst=1 at posedge, highest priority):
  - state=IDLE; dout=0, metric=0, busy=0, done=0.
  - Path metrics and the step counter are cleared.
  - Applies mid-operation too; the in-flight block is discarded.
- FSM: IDLE -> ACS -> TB -> DONE -> (IDLE/ACS).
- IDLE/DONE, start=1 at edge E0:
  - Latch fec_in into an internal register. Later changes to fec_in are ignored.
  - PM[0]=0, PM[1..7]=INIT_INF, step j=0.
  - busy=1, done=0; go to ACS.
- ACS, edges E1..E48, one trellis step per clock for j=0..47:
  - For each next state ns, candidate predecessors are s_b = {ns[1:0], b} for b=0,1, with input u=ns[2].
  - Branch metric = Hamming distance (0..2) between the received pair j and the expected {p1,p0}.
  - Candidate = PM[s_b] + branch metric, saturating.
  - Select the smaller candidate; on a tie select b=0.
  - Write the decision bit b into survivor row j, bit ns. Survivor memory is 48 x 8 bits.
  - All 8 metrics update simultaneously from the previous-cycle values.
- TB, edges E49..E96:
  - At E49, pick the best final state: minimum PM, ties to the lowest index. metric<=that PM.
  - At each TB edge, for step j from 47 down to 0:
    - dout[NBITS-1-j] <= st[2].
    - st <= {st[1:0], surv[j][st]}.
- Completion:
  - At E96, after the j=0 bit is written: done<=1, busy<=0, state=DONE.
  - Latency is exactly 96 clocks from the start-sampling edge to done visible.
- Start handling:
  - start while busy=1 is ignored, with no effect on the running block.
  - start in DONE is accepted as in IDLE; done drops on that edge.
  - dout/metric keep their old values until overwritten during TB.
- rst and start in the same cycle: rst wins.
- Saturation: metrics never wrap. With the defaults the maximum reachable value is 160 < 255, but the saturation logic is still required.

Test Plan:
- fec_in=0, start pulse -> done rises 96 clocks later; dout=48'h0, metric=0; busy high for exactly those 96 cycles.
- fec_in=96'hDF0000000000000000000000 (impulse: input 1 then 47 zeros) -> dout=48'h800000000000, metric=0.
- Same impulse codeword with bit 50 flipped -> dout=48'h800000000000, metric=1.
- Encode random 48-bit vector 48'hA5C3_1E96_0F7B (bench reference model); flip two bits ≥20 pairs apart -> dout equals the original vector, metric=2.
- rst asserted at clock 30 of a run -> next cycle busy=0, done=0, dout=0. A new start then decodes normally in 96 clocks.
- start pulsed again at clock 10 of a run with a different fec_in -> ignored; the first block's result appears at clock 96. A start in DONE the next cycle decodes the second codeword and drops done on its acceptance edge.
